avalon_st_xfade_mux: RTL and testbench

Parametrised N-channel Avalon-ST sample selector: the next-generation replacement for the fixed 12-bit, 4-input filter switcher between the filter bank and `dac_serial`. It synchronises and debounces an asynchronous select (board switches), changes channel only on sample boundaries, and crossfades linearly from the old channel to the new one over 2^FADE_LOG2 samples to suppress audible clicks. All logic runs in the `clk_20` sample domain.

---
 rtl/avalon_st_xfade_mux_pkg.sv | 23 ++
 rtl/avalon_st_xfade_mux_if.sv | 28 ++
 rtl/avalon_st_xfade_mux_select_debounce.sv | 42 ++++
 rtl/avalon_st_xfade_mux.sv | 175 +++++++++++++++++
 tb/tb_avalon_st_xfade_mux.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_st_xfade_mux_pkg.sv
// Shared constants and types for the Avalon-ST crossfading sample selector.
package avalon_st_pkg;

   localparam int AST_ERR_W = 2;

   typedef enum logic [0:0] {
      PASS = 1'b0,
      FADE = 1'b1
   } xfade_state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/avalon_st_xfade_mux_if.sv
// Sink/source bundle of the crossfading selector; master drives the sinks, slave is the mux.
interface avalon_st_xfade_mux_if
   import avalon_st_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int N_CH   = 4,
   parameter int SEL_W  = 2
);
   logic [SEL_W-1:0]          select;
   logic [N_CH*DATA_W-1:0]    sink_data;
   logic [N_CH-1:0]           sink_valid;
   logic [N_CH*AST_ERR_W-1:0] sink_error;
   logic [DATA_W-1:0]         source_data;
   logic                      source_valid;
   logic [AST_ERR_W-1:0]      source_error;
   logic [SEL_W-1:0]          active_ch;
   logic                      fading;

   modport master (
      output select, sink_data, sink_valid, sink_error,
      input  source_data, source_valid, source_error, active_ch, fading
   );

   modport slave (
      input  select, sink_data, sink_valid, sink_error,
      output source_data, source_valid, source_error, active_ch, fading
   );
endinterface

// File: rtl/avalon_st_xfade_mux_select_debounce.sv
// Two-flop synchroniser for the asynchronous select plus a stability counter.
module select_debounce
   import avalon_st_pkg::*;
#(
   parameter int SEL_W        = 2,
   parameter int DEBOUNCE_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [SEL_W-1:0] select,
   output logic [SEL_W-1:0] req_ch,
   output logic             req_stable
);

   localparam int               CNT_W   = clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC);

   logic [SEL_W-1:0] r_sync1;
   logic [SEL_W-1:0] r_sync2;
   logic [CNT_W-1:0] r_cnt;

   // Counter restarts on the edge where the synchronised value is about to change.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= select;
         r_sync2 <= r_sync1;
         if (r_sync1 != r_sync2) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign req_ch     = r_sync2;
   assign req_stable = (r_cnt == CNT_MAX);

endmodule

// File: rtl/avalon_st_xfade_mux.sv
// N-channel Avalon-ST selector that switches on sample boundaries and crossfades
// linearly from the previous channel's held sample over 2^FADE_LOG2 samples.
module avalon_st_xfade_mux
   import avalon_st_pkg::*;
#(
   parameter int DATA_W       = 12,
   parameter int N_CH         = 4,
   parameter int SEL_W        = 2,
   parameter int FADE_LOG2    = 3,
   parameter int DEBOUNCE_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 reset_n,
   avalon_st_xfade_mux_if.slave bus
);

   localparam int                K_W    = FADE_LOG2 + 1;
   localparam int                BW     = DATA_W + FADE_LOG2 + 1;
   localparam logic [K_W-1:0]    K_LAST = K_W'((1 << FADE_LOG2) - 1);
   localparam logic [BW-1:0]     S_BW   = BW'(1) << FADE_LOG2;

   logic [SEL_W-1:0]     w_req_ch;
   logic                 w_req_stable;
   logic                 w_req_in_range;
   logic                 w_commit;
   logic                 w_act_valid;
   logic [DATA_W-1:0]    w_act_data;
   logic [AST_ERR_W-1:0] w_act_err;
   logic [DATA_W-1:0]    w_out_data;
   logic [AST_ERR_W-1:0] w_out_err;
   logic [BW-1:0]        w_prod_old;
   logic [BW-1:0]        w_prod_new;
   xfade_state_e         w_state_nxt;

   logic [DATA_W-1:0]    w_sink_data [N_CH];
   logic [AST_ERR_W-1:0] w_sink_err  [N_CH];

   xfade_state_e         r_state;
   logic [SEL_W-1:0]     r_active_ch;
   logic [SEL_W-1:0]     r_prev_ch;
   logic [K_W-1:0]       r_k;
   logic                 r_fading;
   logic [DATA_W-1:0]    r_hold_data [N_CH];
   logic [AST_ERR_W-1:0] r_hold_err  [N_CH];
   logic [DATA_W-1:0]    r_src_data;
   logic                 r_src_valid;
   logic [AST_ERR_W-1:0] r_src_err;

   select_debounce #(
      .SEL_W        (SEL_W),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_select_debounce (
      .clk        (clk),
      .reset_n    (reset_n),
      .select     (bus.select),
      .req_ch     (w_req_ch),
      .req_stable (w_req_stable)
   );

   for (genvar c = 0; c < N_CH; c++) begin : g_unpack
      assign w_sink_data[c] = bus.sink_data[c*DATA_W +: DATA_W];
      assign w_sink_err[c]  = bus.sink_error[c*AST_ERR_W +: AST_ERR_W];
   end

   assign w_req_in_range = ({1'b0, w_req_ch} < (SEL_W+1)'(N_CH));
   assign w_act_valid    = bus.sink_valid[r_active_ch];
   assign w_act_data     = w_sink_data[r_active_ch];
   assign w_act_err      = w_sink_err[r_active_ch];

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= PASS;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: commits only from PASS; FADE ends after the output with k = S-1.
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      case (r_state)
         PASS: begin
            if (w_req_stable && w_req_in_range && (w_req_ch != r_active_ch)) begin
               w_commit = 1'b1;
               if (FADE_LOG2 > 0) begin
                  w_state_nxt = FADE;
               end else begin
                  w_state_nxt = PASS;
               end
            end else begin
               w_state_nxt = PASS;
            end
         end
         FADE: begin
            if (w_act_valid && (r_k == K_LAST)) begin
               w_state_nxt = PASS;
            end else begin
               w_state_nxt = FADE;
            end
         end
         default: w_state_nxt = PASS;
      endcase
   end

   // Output sample: straight pass-through, or old hold weighted (S-k) against new sample weighted k.
   always_comb begin
      w_prod_old = BW'(r_hold_data[r_prev_ch]) * (S_BW - BW'(r_k));
      w_prod_new = BW'(w_act_data) * BW'(r_k);
      w_out_data = w_act_data;
      w_out_err  = w_act_err;
      case (r_state)
         PASS: begin
            w_out_data = w_act_data;
            w_out_err  = w_act_err;
         end
         FADE: begin
            w_out_data = DATA_W'((w_prod_old + w_prod_new) >> FADE_LOG2);
            w_out_err  = r_hold_err[r_prev_ch] | w_act_err;
         end
         default: begin
            w_out_data = w_act_data;
            w_out_err  = w_act_err;
         end
      endcase
   end

   // Hold registers, channel bookkeeping, fade counter and registered source outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int c = 0; c < N_CH; c++) begin
            r_hold_data[c] <= '0;
            r_hold_err[c]  <= '0;
         end
         r_active_ch <= '0;
         r_prev_ch   <= '0;
         r_k         <= '0;
         r_fading    <= 1'b0;
         r_src_data  <= '0;
         r_src_valid <= 1'b0;
         r_src_err   <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (bus.sink_valid[c]) begin
               r_hold_data[c] <= w_sink_data[c];
               r_hold_err[c]  <= w_sink_err[c];
            end
         end
         r_src_valid <= w_act_valid;
         if (w_act_valid) begin
            r_src_data <= w_out_data;
            r_src_err  <= w_out_err;
         end
         if (w_commit) begin
            r_prev_ch   <= r_active_ch;
            r_active_ch <= w_req_ch;
            r_k         <= K_W'(1);
            r_fading    <= (FADE_LOG2 > 0);
         end else if ((r_state == FADE) && w_act_valid) begin
            r_k <= r_k + K_W'(1);
            if (r_k == K_LAST) begin
               r_fading <= 1'b0;
            end
         end
      end
   end

   assign bus.source_data  = r_src_data;
   assign bus.source_valid = r_src_valid;
   assign bus.source_error = r_src_err;
   assign bus.active_ch    = r_active_ch;
   assign bus.fading       = r_fading;

endmodule

// File: tb/tb_avalon_st_xfade_mux.sv
// Self-checking bench: pass-through vector table plus hand-written select/fade/reset sequences,
// with a scoreboard queue checked whenever the source produces a sample.
module tb_avalon_st_xfade_mux;

   typedef struct {
      int         ch;
      logic [11:0] data;
      logic [1:0]  err;
      bit          exp_out;
      logic [11:0] exp_data;
      logic [1:0]  exp_err;
   } vec_t;

   typedef struct {
      logic [11:0] data;
      logic [1:0]  err;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[7];

   avalon_st_xfade_mux_if #(.DATA_W(12), .N_CH(4), .SEL_W(2)) bus ();
   avalon_st_xfade_mux_if #(.DATA_W(12), .N_CH(3), .SEL_W(2)) bus3 ();

   avalon_st_xfade_mux #(
      .DATA_W(12), .N_CH(4), .SEL_W(2), .FADE_LOG2(2), .DEBOUNCE_CYC(4)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   avalon_st_xfade_mux #(
      .DATA_W(12), .N_CH(3), .SEL_W(2), .FADE_LOG2(2), .DEBOUNCE_CYC(4)
   ) u_dut3 (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One-cycle valid on channel ch of the 4-channel DUT; optionally queue the expected output.
   task automatic pulse(input int ch, input logic [11:0] d, input logic [1:0] e,
                        input bit exp_out, input logic [11:0] xd, input logic [1:0] xe);
      exp_t x;
      bus.sink_valid          = '0;
      bus.sink_valid[ch]      = 1'b1;
      bus.sink_data[ch*12 +: 12] = d;
      bus.sink_error[ch*2 +: 2]  = e;
      if (exp_out) begin
         x.data = xd;
         x.err  = xe;
         sb.push_back(x);
      end
      step(1);
      bus.sink_valid = '0;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (sb.size() != 0 && b < 20) begin
         step(1);
         b++;
      end
      check("scoreboard_drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (bus.source_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got data 0x%0h with no sample expected at %0t",
                     bus.source_data, $time);
         end else begin
            mon_e = sb.pop_front();
            check("out_data", bus.source_data, mon_e.data);
            check("out_err", bus.source_error, mon_e.err);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{0, 12'h123, 2'b00, 1'b1, 12'h123, 2'b00};
      vecs[1] = '{1, 12'h456, 2'b10, 1'b0, 12'h000, 2'b00};
      vecs[2] = '{0, 12'hFFF, 2'b11, 1'b1, 12'hFFF, 2'b11};
      vecs[3] = '{3, 12'h001, 2'b01, 1'b0, 12'h000, 2'b00};
      vecs[4] = '{0, 12'h000, 2'b10, 1'b1, 12'h000, 2'b10};
      vecs[5] = '{2, 12'hC00, 2'b00, 1'b0, 12'h000, 2'b00};
      vecs[6] = '{0, 12'h800, 2'b01, 1'b1, 12'h800, 2'b01};

      reset_n         = 1'b0;
      bus.select      = '0;
      bus.sink_valid  = '0;
      bus.sink_data   = '0;
      bus.sink_error  = '0;
      bus3.select     = '0;
      bus3.sink_valid = '0;
      bus3.sink_data  = '0;
      bus3.sink_error = '0;
      step(3);
      check("rst_source_data", bus.source_data, 0);
      check("rst_source_valid", bus.source_valid, 0);
      check("rst_source_error", bus.source_error, 0);
      check("rst_active_ch", bus.active_ch, 0);
      check("rst_fading", bus.fading, 0);
      reset_n = 1'b1;
      step(2);

      // Pass-through on channel 0; other channels only load their hold registers.
      for (int i = 0; i < 7; i++) begin
         pulse(vecs[i].ch, vecs[i].data, vecs[i].err,
               vecs[i].exp_out, vecs[i].exp_data, vecs[i].exp_err);
         step(1);
      end
      drain();
      check("table_active_ch", bus.active_ch, 0);

      // Short select glitch must not commit.
      bus.select = 2'd1;
      step(3);
      bus.select = 2'd0;
      step(12);
      check("glitch_active_ch", bus.active_ch, 0);
      check("glitch_fading", bus.fading, 0);

      // Fade 0 -> 2: hold 0x800 (err 01) into 0xC00, commit after 2+4+1 clocks.
      bus.select = 2'd2;
      step(6);
      check("commit_not_early", bus.active_ch, 0);
      step(1);
      check("commit_active_ch", bus.active_ch, 2);
      check("commit_fading", bus.fading, 1);
      pulse(2, 12'hC00, 2'b00, 1'b1, 12'h900, 2'b01);
      step(1);
      check("fade_k2_fading", bus.fading, 1);
      pulse(2, 12'hC00, 2'b00, 1'b1, 12'hA00, 2'b01);
      step(1);
      pulse(2, 12'hC00, 2'b00, 1'b1, 12'hB00, 2'b01);
      step(1);
      pulse(2, 12'hC00, 2'b00, 1'b1, 12'hC00, 2'b00);
      check("fade_done_fading", bus.fading, 0);
      check("fade_done_active", bus.active_ch, 2);
      drain();

      // Fade 2 -> 0 with select moving to 1 mid-fade; 0 -> 1 starts on the first PASS cycle.
      bus.select = 2'd0;
      step(7);
      check("f2_commit_active", bus.active_ch, 0);
      check("f2_commit_fading", bus.fading, 1);
      bus.select = 2'd1;
      step(1);
      pulse(0, 12'h400, 2'b00, 1'b1, 12'hA00, 2'b00);
      step(1);
      pulse(0, 12'h400, 2'b00, 1'b1, 12'h800, 2'b00);
      step(1);
      pulse(0, 12'h400, 2'b00, 1'b1, 12'h600, 2'b00);
      check("f2_end_active", bus.active_ch, 0);
      check("f2_end_fading", bus.fading, 0);
      step(1);
      check("f3_commit_active", bus.active_ch, 1);
      check("f3_commit_fading", bus.fading, 1);
      pulse(1, 12'h000, 2'b10, 1'b1, 12'h300, 2'b10);
      pulse(1, 12'h000, 2'b10, 1'b1, 12'h200, 2'b10);
      pulse(1, 12'h000, 2'b10, 1'b1, 12'h100, 2'b10);
      pulse(1, 12'h000, 2'b10, 1'b1, 12'h000, 2'b10);
      check("f3_end_fading", bus.fading, 0);
      drain();

      // Three-channel instance: out-of-range select 3 is ignored, pass-through continues.
      bus3.select = 2'd3;
      for (int i = 0; i < 5; i++) begin
         bus3.sink_valid       = 3'b001;
         bus3.sink_data[11:0]  = 12'h0A5 + 12'(i * 256);
         step(1);
         bus3.sink_valid = '0;
         check("n3_valid", bus3.source_valid, 1);
         check("n3_data", bus3.source_data, 12'h0A5 + 12'(i * 256));
         step(3);
      end
      check("n3_active_ch", bus3.active_ch, 0);
      check("n3_fading", bus3.fading, 0);

      // Reset with k=2 mid-fade and an active-channel valid in the same cycle.
      bus.select = 2'd2;
      step(7);
      check("f4_commit_active", bus.active_ch, 2);
      pulse(2, 12'h400, 2'b00, 1'b1, 12'h100, 2'b10);
      drain();
      reset_n = 1'b0;
      bus.select = 2'd0;
      bus.sink_valid = 4'b0100;
      step(1);
      bus.sink_valid = '0;
      check("mid_rst_valid", bus.source_valid, 0);
      check("mid_rst_data", bus.source_data, 0);
      check("mid_rst_error", bus.source_error, 0);
      check("mid_rst_active", bus.active_ch, 0);
      check("mid_rst_fading", bus.fading, 0);
      step(2);
      reset_n = 1'b1;
      step(10);
      check("post_rst_active", bus.active_ch, 0);
      check("post_rst_fading", bus.fading, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
